// File: rtl/afl_fetch_sequencer.sv
// Column-step SRAM read sequencer feeding the aligned feature loader. It issues one read
// per input word and returns each word two cycles later, tagged with its feeder offset.
module afl_fetch_sequencer #(
    parameter int aflDimY      = 128,
    parameter int inputWidth   = 32,
    parameter int elementWidth = 4,
    parameter int kernelWidth  = 3,
    parameter int addrWidth    = 16,
    parameter int colWidth     = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic [addrWidth-1:0]           cfg_base_addr_i,
    input  logic [addrWidth-1:0]           cfg_col_stride_i,
    input  logic [colWidth-1:0]            cfg_num_cols_i,
    input  logic                           stall_i,
    output logic                           sram_rd_en_o,
    output logic [addrWidth-1:0]           sram_addr_o,
    input  logic [inputWidth-1:0]          sram_rd_data_i,
    output logic [inputWidth-1:0]          data_o,
    output logic [aflDimY/kernelWidth-1:0] feeder_offset_o,
    output logic                           valid_o,
    output logic                           col_done_o,
    output logic                           done_o,
    output logic                           busy_o
);
    localparam int NUM_FEEDERS    = aflDimY / kernelWidth;
    localparam int INPUT_ELEMENTS = inputWidth / elementWidth;
    localparam int WORDS_PER_COL  = (NUM_FEEDERS + INPUT_ELEMENTS - 1) / INPUT_ELEMENTS;
    localparam int WORD_W         = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_COL - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [colWidth-1:0]    col_q, col_d;
    logic [colWidth-1:0]    num_cols_q, num_cols_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [addrWidth-1:0]   col_base_q, col_base_d;
    logic [addrWidth-1:0]   stride_q, stride_d;
    logic                   s1_valid_q, s1_valid_d;
    logic                   s1_last_col_q, s1_last_col_d;
    logic [WORD_W-1:0]      s1_word_q, s1_word_d;
    logic [inputWidth-1:0]  data_q, data_d;
    logic [NUM_FEEDERS-1:0] offset_q, offset_d;
    logic                   valid_q, valid_d;
    logic                   col_done_q, col_done_d;
    logic                   done_q, done_d;
    logic                   last_word, last_col;

    always_comb begin
        last_word    = (word_q == LAST_WORD);
        last_col     = (col_q == num_cols_q - colWidth'(1));
        sram_rd_en_o = (state_q == ST_ISSUE) && !stall_i;
        // col_base_q tracks base + col*stride, so only the word index is added here
        sram_addr_o  = col_base_q + addrWidth'(word_q);

        state_d    = state_q;
        col_d      = col_q;
        num_cols_d = num_cols_q;
        word_d     = word_q;
        col_base_d = col_base_q;
        stride_d   = stride_q;

        s1_valid_d    = sram_rd_en_o;
        s1_word_d     = word_q;
        s1_last_col_d = last_col;

        valid_d    = s1_valid_q;
        data_d     = s1_valid_q ? sram_rd_data_i : data_q;
        offset_d   = s1_valid_q ? NUM_FEEDERS'(s1_word_q) * NUM_FEEDERS'(INPUT_ELEMENTS)
                                : offset_q;
        col_done_d = s1_valid_q && (s1_word_q == LAST_WORD);
        done_d     = s1_valid_q && (s1_word_q == LAST_WORD) && s1_last_col_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (cfg_num_cols_i != '0) begin
                        col_base_d = cfg_base_addr_i;
                        stride_d   = cfg_col_stride_i;
                        num_cols_d = cfg_num_cols_i;
                        col_d      = '0;
                        word_d     = '0;
                        state_d    = ST_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (sram_rd_en_o) begin
                    if (last_word) begin
                        word_d     = '0;
                        col_d      = col_q + colWidth'(1);
                        col_base_d = col_base_q + stride_q;
                        if (last_col) state_d = ST_DRAIN;
                    end else begin
                        word_d = word_q + WORD_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (done_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            col_q         <= '0;
            num_cols_q    <= '0;
            word_q        <= '0;
            col_base_q    <= '0;
            stride_q      <= '0;
            s1_valid_q    <= 1'b0;
            s1_last_col_q <= 1'b0;
            s1_word_q     <= '0;
            data_q        <= '0;
            offset_q      <= '0;
            valid_q       <= 1'b0;
            col_done_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            num_cols_q    <= num_cols_d;
            word_q        <= word_d;
            col_base_q    <= col_base_d;
            stride_q      <= stride_d;
            s1_valid_q    <= s1_valid_d;
            s1_last_col_q <= s1_last_col_d;
            s1_word_q     <= s1_word_d;
            data_q        <= data_d;
            offset_q      <= offset_d;
            valid_q       <= valid_d;
            col_done_q    <= col_done_d;
            done_q        <= done_d;
        end
    end

    assign data_o          = data_q;
    assign feeder_offset_o = offset_q;
    assign valid_o         = valid_q;
    assign col_done_o      = col_done_q;
    assign done_o          = done_q;
    assign busy_o          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_afl_fetch_sequencer.sv
// Scoreboard bench for afl_fetch_sequencer: jobs enqueue the expected read addresses and
// returned words; independent monitors pop and compare whenever the DUT presents them.
module tb_afl_fetch_sequencer;
    localparam int AW  = 16;
    localparam int CW  = 12;
    localparam int IW  = 32;
    localparam int NF  = 42;
    localparam int WPC = 6;
    localparam int IE  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i, stall_i;
    logic [AW-1:0] cfg_base_addr_i, cfg_col_stride_i;
    logic [CW-1:0] cfg_num_cols_i;
    logic          sram_rd_en_o;
    logic [AW-1:0] sram_addr_o;
    logic [IW-1:0] sram_rd_data_i;
    logic [IW-1:0] data_o;
    logic [NF-1:0] feeder_offset_o;
    logic          valid_o, col_done_o, done_o, busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [AW-1:0] addr;
        int            off;
        bit            cd;
        bit            dn;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];

    bit            mon_en = 0;
    bit            done_seen = 0;
    int            done_cyc = 0;
    bit            done_valid = 0;
    bit            rd_d1 = 0, rd_d2 = 0;
    logic [IW-1:0] last_data = '0;

    afl_fetch_sequencer #(
        .aflDimY(128), .inputWidth(32), .elementWidth(4),
        .kernelWidth(3), .addrWidth(16), .colWidth(12)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .cfg_base_addr_i(cfg_base_addr_i), .cfg_col_stride_i(cfg_col_stride_i),
        .cfg_num_cols_i(cfg_num_cols_i), .stall_i(stall_i),
        .sram_rd_en_o(sram_rd_en_o), .sram_addr_o(sram_addr_o),
        .sram_rd_data_i(sram_rd_data_i), .data_o(data_o),
        .feeder_offset_o(feeder_offset_o), .valid_o(valid_o),
        .col_done_o(col_done_o), .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    // One-cycle-latency SRAM; returns noise when not read so stale capture is visible
    always @(posedge clk) begin
        if (sram_rd_en_o) sram_rd_data_i <= mem(sram_addr_o);
        else              sram_rd_data_i <= $urandom();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("valid_latency", valid_o, rd_d2);
            if (stall_i && sram_rd_en_o) check("rd_during_stall", 1, 0);
            if (sram_rd_en_o && !rst) begin
                if (addr_q.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_addr", sram_addr_o, addr_q.pop_front());
            end
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check("valid_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", data_o, mem(e.addr));
                    check("offset", feeder_offset_o, 64'(e.off));
                    check("col_done", col_done_o, e.cd);
                    check("done_flag", done_o, e.dn);
                end
                last_data = data_o;
            end else begin
                check("data_hold", data_o, last_data);
                check("col_done_idle", col_done_o, 0);
            end
            if (done_o) begin
                done_seen  = 1;
                done_cyc   = cyc;
                done_valid = valid_o;
            end
            rd_d2 = rd_d1;
            rd_d1 = sram_rd_en_o && !rst;
            if (rst) begin
                rd_d1 = 0;
                rd_d2 = 0;
                last_data = '0;
                exp_q.delete();
                addr_q.delete();
            end
        end
    end

    // stall_mode: 0 none, 1 three cycles after the 2nd read, 2 random
    task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input int ncols, input int stall_mode,
                           input int repulse_at, input int abort_at);
        int remaining, issued, stalled, last_issue, t;
        bit stall;
        for (int c = 0; c < ncols; c++) begin
            for (int w = 0; w < WPC; w++) begin
                logic [AW-1:0] a;
                a = base + AW'(c) * stride + AW'(w);
                addr_q.push_back(a);
                exp_q.push_back('{addr: a, off: w * IE, cd: (w == WPC - 1),
                                  dn: (w == WPC - 1) && (c == ncols - 1)});
            end
        end
        @(posedge clk); #1;
        done_seen        = 0;
        start_i          = 1;
        cfg_base_addr_i  = base;
        cfg_col_stride_i = stride;
        cfg_num_cols_i   = CW'(ncols);
        @(posedge clk); #1;
        start_i          = 0;
        cfg_base_addr_i  = AW'($urandom());
        cfg_col_stride_i = AW'($urandom());
        cfg_num_cols_i   = CW'($urandom());
        if (ncols == 0) begin
            @(negedge clk);
            check("zero_done", done_o, 1);
            check("zero_valid", valid_o, 0);
            check("zero_busy", busy_o, 0);
            @(negedge clk);
            check("zero_done_pulse", done_o, 0);
            check("zero_busy_after", busy_o, 0);
            return;
        end
        check("busy_start", busy_o, 1);
        remaining  = ncols * WPC;
        issued     = 0;
        stalled    = 0;
        last_issue = -1;
        while (remaining > 0) begin
            if (abort_at > 0 && issued == abort_at) begin
                stall_i = 0;
                rst     = 1;
                @(posedge clk); #1;
                rst = 0;
                @(negedge clk);
                check("abort_rd_en", sram_rd_en_o, 0);
                check("abort_addr", sram_addr_o, 0);
                check("abort_valid", valid_o, 0);
                check("abort_done", done_o, 0);
                check("abort_busy", busy_o, 0);
                check("abort_col_done", col_done_o, 0);
                check("abort_data", data_o, 0);
                check("abort_offset", feeder_offset_o, 0);
                repeat (4) @(negedge clk);
                check("abort_queue", exp_q.size(), 0);
                return;
            end
            case (stall_mode)
                1:       stall = (issued == 2) && (stalled < 3);
                2:       stall = ($urandom_range(0, 3) == 0);
                default: stall = 0;
            endcase
            stall_i = stall;
            if (stall) begin
                stalled++;
            end else begin
                issued++;
                remaining--;
                last_issue = cyc;
                if (repulse_at > 0 && issued == repulse_at) begin
                    start_i          = 1;
                    cfg_base_addr_i  = base + 16'h0400;
                    cfg_col_stride_i = stride + 16'h0003;
                    cfg_num_cols_i   = CW'(ncols + 2);
                end
            end
            @(posedge clk); #1;
            start_i = 0;
        end
        stall_i = 0;
        t = 0;
        while (!done_seen && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("done_seen", done_seen, 1);
        check("done_latency", done_cyc, last_issue + 2);
        check("done_with_valid", done_valid, 1);
        @(negedge clk);
        check("busy_after_done", busy_o, 0);
        check("done_one_cycle", done_o, 0);
        check("addr_queue_empty", addr_q.size(), 0);
        check("word_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1; start_i = 0; stall_i = 0;
        cfg_base_addr_i = '0; cfg_col_stride_i = '0; cfg_num_cols_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", sram_rd_en_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_done", done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_col_done", col_done_o, 0);
        check("rst_data", data_o, 0);
        check("rst_offset", feeder_offset_o, 0);
        @(posedge clk); #1;
        rst    = 0;
        mon_en = 1;

        run_job(16'h0100, 16'h0010, 2, 0, 0, 0);
        run_job(16'h0100, 16'h0010, 2, 1, 0, 0);
        run_job(16'h0100, 16'h0010, 0, 0, 0, 0);
        run_job(16'h0100, 16'h0010, 2, 0, 3, 0);
        run_job(16'h0100, 16'h0010, 2, 0, 0, 4);
        run_job(16'h0100, 16'h0010, 2, 0, 0, 0);
        run_job(16'hFFFC, 16'h0002, 1, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            run_job(AW'($urandom()), AW'($urandom()), $urandom_range(1, 3), 2,
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0, 0);
        end
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
